// File: rtl/twiddle_mult.sv
// FFT inter-stage twiddle multiplier: generates the twiddle ROM address per sample
// and computes a rounded, saturated complex product over a 3-cycle pipeline.
module twiddle_mult #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TW_WIDTH   = 16,
  parameter int unsigned LOG2N      = 8,
  parameter int unsigned STAGE      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_sop,
  input  logic [2*DATA_WIDTH-1:0]   in_data,
  output logic [LOG2N-2:0]          tw_addr,
  input  logic [2*TW_WIDTH-1:0]     tw_data,
  output logic                      out_valid,
  output logic                      out_sop,
  output logic [2*DATA_WIDTH-1:0]   out_data
);

  localparam int unsigned AW = LOG2N - 1;
  localparam int unsigned KW = LOG2N - 1 - STAGE;
  localparam int unsigned PW = DATA_WIDTH + TW_WIDTH;
  localparam int unsigned SW = PW + 1;

  localparam logic signed [SW-1:0] RND  = SW'(2 ** (TW_WIDTH - 2));
  localparam logic signed [SW-1:0] SMAX = SW'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] SMIN = -SMAX - SW'(1);

  // Twiddle address generation
  logic [KW-1:0] k;
  logic [KW-1:0] idx_c;
  logic [AW-1:0] addr_c;
  logic [AW-1:0] addr_q;

  assign idx_c   = (in_valid && in_sop) ? '0 : k;
  assign addr_c  = AW'(idx_c) << STAGE;
  assign tw_addr = in_valid ? addr_c : addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k      <= '0;
      addr_q <= '0;
    end else if (in_valid) begin
      k      <= idx_c + KW'(1);
      addr_q <= addr_c;
    end
  end

  // S1: input register, aligns the sample with the ROM read data
  logic [2*DATA_WIDTH-1:0] s1_data;
  logic                    s1_valid;
  logic                    s1_sop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
    end else begin
      s1_data  <= in_data;
      s1_valid <= in_valid;
      s1_sop   <= in_valid && in_sop;
    end
  end

  // S2: partial products
  logic signed [DATA_WIDTH-1:0] ar, ai;
  logic signed [TW_WIDTH-1:0]   wr, wi;
  logic signed [PW-1:0]         p_rr, p_ii, p_ri, p_ir;
  logic                         s2_valid;
  logic                         s2_sop;

  assign ar = s1_data[DATA_WIDTH-1:0];
  assign ai = s1_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign wr = tw_data[TW_WIDTH-1:0];
  assign wi = tw_data[2*TW_WIDTH-1:TW_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rr     <= '0;
      p_ii     <= '0;
      p_ri     <= '0;
      p_ir     <= '0;
      s2_valid <= 1'b0;
      s2_sop   <= 1'b0;
    end else begin
      p_rr     <= PW'(ar) * PW'(wr);
      p_ii     <= PW'(ai) * PW'(wi);
      p_ri     <= PW'(ar) * PW'(wi);
      p_ir     <= PW'(ai) * PW'(wr);
      s2_valid <= s1_valid;
      s2_sop   <= s1_sop;
    end
  end

  // S3: sum, round half up, saturate
  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SMAX)      return DATA_WIDTH'(SMAX);
    else if (v < SMIN) return DATA_WIDTH'(SMIN);
    else               return DATA_WIDTH'(v);
  endfunction

  logic signed [SW-1:0] yr_c, yi_c, rr_c, ri_c;

  always_comb begin
    yr_c = SW'(p_rr) - SW'(p_ii);
    yi_c = SW'(p_ri) + SW'(p_ir);
    rr_c = (yr_c + RND) >>> (TW_WIDTH - 1);
    ri_c = (yi_c + RND) >>> (TW_WIDTH - 1);
  end

  // out_data only moves on a valid result so it holds through gaps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= s2_valid;
      out_sop   <= s2_sop;
      if (s2_valid) out_data <= {sat(ri_c), sat(rr_c)};
    end
  end

endmodule
